// File: rtl/ds1302_ctrl.sv
// DS1302 RTC transaction sequencer: periodic time reads and on-demand time writes
// issued as byte commands to an MSB-first SPI byte master.
module ds1302_ctrl #(
  parameter int unsigned CE_SETUP    = 50,
  parameter int unsigned CE_HOLD     = 50,
  parameter int unsigned READ_PERIOD = 25_000_000
) (
  input  logic        spi_clk,
  input  logic        spi_rst,
  input  logic        wr_req,
  input  logic [55:0] wr_time,
  output logic [55:0] rd_time,
  output logic        rd_valid,
  output logic        busy,
  output logic        spi_cs_ctrl,
  output logic        spi_wr_en,
  output logic [7:0]  spi_data_in,
  input  logic [7:0]  spi_data_out,
  input  logic        spi_wr_ack
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_CE_ON, S_SEND, S_WAIT_ACK, S_GAP, S_CE_OFF, S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_op_wr;
  logic             r_txn2;
  logic             r_ce_low;
  logic [IDX_W-1:0] r_idx;
  logic [55:0]      r_wtime;
  logic [55:0]      r_shadow;

  logic             w_wrap;
  logic             w_rd_accept;
  logic [IDX_W-1:0] w_nbytes;
  logic [IDX_W-1:0] w_idx_inc;
  logic [IDX_W-1:0] w_load_idx;
  logic             w_more;
  logic [7:0]       w_byte_nxt;

  function automatic logic [7:0] bitrev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Command/data byte in logical (LSB-first wire) order for a given byte slot
  function automatic logic [7:0] logical_byte(input logic op_wr, input logic txn2,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [55:0] t);
    logic [7:0] b;
    b = 8'h00;
    if (!op_wr) begin
      b = (idx == '0) ? 8'hBF : 8'h00;
    end else if (!txn2) begin
      b = (idx == '0) ? 8'h8E : 8'h00;
    end else begin
      case (idx)
        4'd0:    b = 8'hBE;
        4'd1:    b = t[7:0];
        4'd2:    b = t[15:8];
        4'd3:    b = t[23:16];
        4'd4:    b = t[31:24];
        4'd5:    b = t[39:32];
        4'd6:    b = t[47:40];
        4'd7:    b = t[55:48];
        4'd8:    b = 8'h80;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  assign w_wrap      = (r_per_cnt == CNT_W'(READ_PERIOD - 1));
  assign w_rd_accept = (r_state == S_IDLE) && !wr_req && r_pend;
  assign w_nbytes    = !r_op_wr ? IDX_W'(8) : (r_txn2 ? IDX_W'(9) : IDX_W'(2));
  assign w_idx_inc   = r_idx + IDX_W'(1);
  assign w_more      = (w_idx_inc < w_nbytes);
  assign w_load_idx  = (r_state == S_GAP) ? w_idx_inc : '0;
  assign w_byte_nxt  = bitrev(logical_byte(r_op_wr, r_txn2, w_load_idx, r_wtime));
  assign busy        = (r_state != S_IDLE);

  // Free-running read timer; a wrap while a read is already pending is absorbed
  always_ff @(posedge spi_clk or posedge spi_rst) begin
    if (spi_rst) begin
      r_per_cnt <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_per_cnt <= w_wrap ? '0 : r_per_cnt + 1'b1;
      if (w_wrap)           r_pend <= 1'b1;
      else if (w_rd_accept) r_pend <= 1'b0;
    end
  end

  always_ff @(posedge spi_clk or posedge spi_rst) begin
    if (spi_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op_wr     <= 1'b0;
      r_txn2      <= 1'b0;
      r_ce_low    <= 1'b0;
      r_idx       <= '0;
      r_wtime     <= '0;
      r_shadow    <= '0;
      rd_time     <= '0;
      rd_valid    <= 1'b0;
      spi_cs_ctrl <= 1'b0;
      spi_wr_en   <= 1'b0;
      spi_data_in <= '0;
    end else begin
      rd_valid  <= 1'b0;
      spi_wr_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_idx    <= '0;
          r_txn2   <= 1'b0;
          r_ce_low <= 1'b0;
          if (wr_req) begin
            r_op_wr     <= 1'b1;
            r_wtime     <= wr_time;
            spi_cs_ctrl <= 1'b1;
            r_state     <= S_CE_ON;
          end else if (r_pend) begin
            r_op_wr     <= 1'b0;
            spi_cs_ctrl <= 1'b1;
            r_state     <= S_CE_ON;
          end
        end
        S_CE_ON: begin
          if (r_cnt == CNT_W'(CE_SETUP - 1)) begin
            r_idx       <= '0;
            spi_data_in <= w_byte_nxt;
            spi_wr_en   <= 1'b1;
            r_state     <= S_SEND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SEND: r_state <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (spi_wr_ack) begin
            // Dummy read byte k lands in time byte k
            if (!r_op_wr) begin
              for (int k = 0; k < 7; k++) begin
                if (r_idx == IDX_W'(k + 1)) r_shadow[8*k +: 8] <= bitrev(spi_data_out);
              end
            end
            r_cnt   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt <= '0;
            if (w_more) begin
              r_idx       <= w_idx_inc;
              spi_data_in <= w_byte_nxt;
              spi_wr_en   <= 1'b1;
              r_state     <= S_SEND;
            end else begin
              r_state <= S_CE_OFF;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CE_OFF: begin
          // CE held high for CE_HOLD, then kept low for CE_HOLD before anything else
          if (r_cnt != CNT_W'(CE_HOLD - 1)) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!r_ce_low) begin
            spi_cs_ctrl <= 1'b0;
            r_ce_low    <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_ce_low <= 1'b0;
            r_cnt    <= '0;
            if (r_op_wr && !r_txn2) begin
              r_txn2      <= 1'b1;
              r_idx       <= '0;
              spi_cs_ctrl <= 1'b1;
              r_state     <= S_CE_ON;
            end else if (!r_op_wr) begin
              rd_time  <= r_shadow;
              rd_valid <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
